// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the 4-master bus arbiter: state encoding, widths
// and a small one-hot helper.
package bus_arbiter_pkg;

  localparam int unsigned NR_OF_MASTERS = 4;
  localparam int unsigned OWNER_W       = 2;
  localparam int unsigned BEGIN_CNT_W   = 8;
  localparam int unsigned ACTIVE_CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } arb_state_t;

  // One-hot grant vector for a master index.
  function automatic logic [NR_OF_MASTERS-1:0] owner_onehot(input logic [OWNER_W-1:0] idx);
    logic [NR_OF_MASTERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Arbiter bus bundle.
//   master modport : request/begin/end/error driven by the masters and slaves,
//                    grant/status observed.
//   slave modport  : the arbiter's view (requests in, grant/status out).
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic [NR_OF_MASTERS-1:0] requestBus;
  logic [NR_OF_MASTERS-1:0] beginTransaction;
  logic [NR_OF_MASTERS-1:0] endTransaction;
  logic                     busErrorIn;
  logic [NR_OF_MASTERS-1:0] busGrant;
  logic [OWNER_W-1:0]       busOwner;
  logic                     busActive;
  logic                     timeoutPulse;
  logic                     forceEndTransaction;

  modport master (
    output requestBus, beginTransaction, endTransaction, busErrorIn,
    input  busGrant, busOwner, busActive, timeoutPulse, forceEndTransaction
  );

  modport slave (
    input  requestBus, beginTransaction, endTransaction, busErrorIn,
    output busGrant, busOwner, busActive, timeoutPulse, forceEndTransaction
  );

endinterface

// File: rtl/bus_arbiter_round_robin.sv
// Combinational round-robin pick.
//   request   : per-master request bits
//   lastOwner : previous owner; search starts one past it and wraps 3->0
//   winner    : selected master index (0 when nothing requested)
//   valid     : at least one request present
module roundRobinSelect
  import bus_arbiter_pkg::*;
(
  input  logic [NR_OF_MASTERS-1:0] request,
  input  logic [OWNER_W-1:0]       lastOwner,
  output logic [OWNER_W-1:0]       winner,
  output logic                     valid
);

  logic [OWNER_W-1:0] w_idx;

  // Offsets 1..4 from lastOwner; the 2-bit add wraps naturally, and offset 4
  // lands back on lastOwner so it is considered last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    w_idx  = '0;
    for (int unsigned i = 1; i <= NR_OF_MASTERS; i++) begin
      w_idx = lastOwner + OWNER_W'(i);
      if (!valid && request[w_idx]) begin
        winner = w_idx;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Four-master round-robin bus arbiter with begin and active timeouts.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : requestBus/beginTransaction/endTransaction/busErrorIn in;
//                  busGrant/busOwner/busActive/timeoutPulse/
//                  forceEndTransaction out, all registered
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter logic [BEGIN_CNT_W-1:0]  beginTimeout  = 8'd16,
  parameter logic [ACTIVE_CNT_W-1:0] activeTimeout = 16'd4096
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  arb_state_t               r_state, w_next_state;
  logic [OWNER_W-1:0]       r_owner, w_owner_d;
  logic [OWNER_W-1:0]       r_last_owner, w_last_owner_d;
  logic [BEGIN_CNT_W-1:0]   r_begin_cnt, w_begin_cnt_d;
  logic [ACTIVE_CNT_W-1:0]  r_active_cnt, w_active_cnt_d;
  logic [NR_OF_MASTERS-1:0] r_grant, w_grant_d;
  logic [OWNER_W-1:0]       r_bus_owner, w_bus_owner_d;
  logic                     r_active, w_active_d;
  logic                     r_timeout, w_timeout_d;
  logic                     r_force_end, w_force_end_d;
  logic [OWNER_W-1:0]       w_rr_winner;
  logic                     w_rr_valid;
  logic                     w_holds_bus;

  roundRobinSelect u_rr (
    .request   (bus.requestBus),
    .lastOwner (r_last_owner),
    .winner    (w_rr_winner),
    .valid     (w_rr_valid)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state, counters and next values of the registered outputs.
  always_comb begin
    w_next_state   = r_state;
    w_owner_d      = r_owner;
    w_last_owner_d = r_last_owner;
    w_begin_cnt_d  = r_begin_cnt;
    w_active_cnt_d = r_active_cnt;
    w_timeout_d    = 1'b0;
    w_force_end_d  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_rr_valid) begin
          w_next_state  = GRANTED;
          w_owner_d     = w_rr_winner;
          w_begin_cnt_d = '0;
        end
      end
      GRANTED: begin
        // Begin beats a same-cycle expiry; only the owner's bits matter.
        if (bus.beginTransaction[r_owner]) begin
          w_next_state   = ACTIVE;
          w_active_cnt_d = '0;
        end else if (!bus.requestBus[r_owner]) begin
          w_next_state = RELEASE;
        end else if (r_begin_cnt == beginTimeout - BEGIN_CNT_W'(1)) begin
          w_next_state = RELEASE;
          w_timeout_d  = 1'b1;
        end else begin
          w_begin_cnt_d = r_begin_cnt + BEGIN_CNT_W'(1);
        end
      end
      ACTIVE: begin
        // A normal end or bus error beats a same-cycle expiry.
        if (bus.endTransaction[r_owner] || bus.busErrorIn) begin
          w_next_state = RELEASE;
        end else if (r_active_cnt == activeTimeout - ACTIVE_CNT_W'(1)) begin
          w_next_state  = RELEASE;
          w_timeout_d   = 1'b1;
          w_force_end_d = 1'b1;
        end else if (r_active_cnt != '1) begin
          w_active_cnt_d = r_active_cnt + ACTIVE_CNT_W'(1);
        end
      end
      RELEASE: begin
        // Turnaround cycle: grant already low, remember owner for fairness.
        w_next_state   = IDLE;
        w_last_owner_d = r_owner;
      end
      default: w_next_state = IDLE;
    endcase

    w_holds_bus   = (w_next_state == GRANTED) || (w_next_state == ACTIVE);
    w_grant_d     = w_holds_bus ? owner_onehot(w_owner_d) : '0;
    w_bus_owner_d = w_holds_bus ? w_owner_d : '0;
    // busActive also covers the cycle right after the transaction ends.
    w_active_d    = (w_next_state == ACTIVE) ||
                    ((r_state == ACTIVE) && (w_next_state == RELEASE));
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_owner      <= '0;
      r_last_owner <= OWNER_W'(NR_OF_MASTERS - 1);
      r_begin_cnt  <= '0;
      r_active_cnt <= '0;
      r_grant      <= '0;
      r_bus_owner  <= '0;
      r_active     <= 1'b0;
      r_timeout    <= 1'b0;
      r_force_end  <= 1'b0;
    end else begin
      r_owner      <= w_owner_d;
      r_last_owner <= w_last_owner_d;
      r_begin_cnt  <= w_begin_cnt_d;
      r_active_cnt <= w_active_cnt_d;
      r_grant      <= w_grant_d;
      r_bus_owner  <= w_bus_owner_d;
      r_active     <= w_active_d;
      r_timeout    <= w_timeout_d;
      r_force_end  <= w_force_end_d;
    end
  end

  assign bus.busGrant            = r_grant;
  assign bus.busOwner            = r_bus_owner;
  assign bus.busActive           = r_active;
  assign bus.timeoutPulse        = r_timeout;
  assign bus.forceEndTransaction = r_force_end;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (activeTimeout set to 32).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_bus_arbiter;

  logic clock = 1'b0;
  logic reset;
  int   n_cmp;
  int   n_fail;

  always #5 clock = ~clock;

  bus_arbiter_if bus_if ();

  bus_arbiter #(.beginTimeout(8'd16), .activeTimeout(16'd32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_if)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.requestBus       = 4'b0000;
    bus_if.beginTransaction = 4'b0000;
    bus_if.endTransaction   = 4'b0000;
    bus_if.busErrorIn       = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.requestBus       = 4'b1111;
    bus_if.beginTransaction = 4'b1111;
    tick();
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (bus_if.busOwner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", bus_if.busOwner); end
    n_cmp++; if (bus_if.busActive !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b want 0", bus_if.busActive); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", bus_if.timeoutPulse); end
    n_cmp++; if (bus_if.forceEndTransaction !== 1'b0) begin n_fail++; $display("FAIL reset_force: got %b want 0", bus_if.forceEndTransaction); end
    clear_inputs();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_requesters();
    do_reset();
    bus_if.requestBus = 4'b0110;
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL two_req_no_comb: got %b want 0000", bus_if.busGrant); end
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0010) begin n_fail++; $display("FAIL two_req_first: got %b want 0010", bus_if.busGrant); end
    n_cmp++; if (bus_if.busOwner !== 2'd1) begin n_fail++; $display("FAIL two_req_owner1: got %0d want 1", bus_if.busOwner); end
    bus_if.beginTransaction = 4'b0010;
    tick();
    n_cmp++; if (bus_if.busActive !== 1'b1) begin n_fail++; $display("FAIL two_req_active: got %b want 1", bus_if.busActive); end
    bus_if.beginTransaction = 4'b0000;
    bus_if.endTransaction   = 4'b0010;
    bus_if.requestBus       = 4'b0100;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL two_req_release: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (bus_if.busOwner !== 2'd0) begin n_fail++; $display("FAIL two_req_rel_owner: got %0d want 0", bus_if.busOwner); end
    bus_if.endTransaction = 4'b0000;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL two_req_idle: got %b want 0000", bus_if.busGrant); end
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0100) begin n_fail++; $display("FAIL two_req_second: got %b want 0100", bus_if.busGrant); end
    n_cmp++; if (bus_if.busOwner !== 2'd2) begin n_fail++; $display("FAIL two_req_owner2: got %0d want 2", bus_if.busOwner); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int exp_order [5];
    int got;
    int low;
    int age;
    bit granted;
    exp_order = '{0, 1, 2, 3, 0};
    got = 0; low = 0; age = 0; granted = 1'b0;
    do_reset();
    bus_if.requestBus = 4'b1111;
    for (int cyc = 0; cyc < 200 && got < 5; cyc++) begin
      tick();
      if (bus_if.busGrant != 4'b0000) begin
        if (!granted) begin
          n_cmp++; if (bus_if.busGrant !== 4'(1 << exp_order[got])) begin n_fail++; $display("FAIL rr_order[%0d]: got %b want master %0d", got, bus_if.busGrant, exp_order[got]); end
          if (got > 0) begin
            n_cmp++; if (low !== 2) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d low cycles want 2", got, low); end
          end
          got++;
          age = 0;
          low = 0;
        end else begin
          age++;
        end
        granted = 1'b1;
      end else begin
        granted = 1'b0;
        low++;
      end
      bus_if.beginTransaction = 4'b0000;
      bus_if.endTransaction   = 4'b0000;
      if (granted && age == 0) bus_if.beginTransaction[exp_order[got-1]] = 1'b1;
      if (granted && age == 3) bus_if.endTransaction[exp_order[got-1]] = 1'b1;
    end
    n_cmp++; if (got !== 5) begin n_fail++; $display("FAIL rr_budget: got %0d grants want 5", got); end
    // Owner drops its request while merely granted: release with no timeout.
    clear_inputs();
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL rr_drop_grant: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL rr_drop_timeout: got %b want 0", bus_if.timeoutPulse); end
    tick();
  endtask

  task automatic test_begin_timeout();
    int hi;
    do_reset();
    bus_if.requestBus = 4'b0110;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0010) begin n_fail++; $display("FAIL bto_grant: got %b want 0010", bus_if.busGrant); end
    hi = 1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus_if.busGrant == 4'b0000) break;
      hi++;
    end
    n_cmp++; if (hi !== 16) begin n_fail++; $display("FAIL bto_cycles: got %0d want 16", hi); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b1) begin n_fail++; $display("FAIL bto_pulse: got %b want 1", bus_if.timeoutPulse); end
    n_cmp++; if (bus_if.forceEndTransaction !== 1'b0) begin n_fail++; $display("FAIL bto_force: got %b want 0", bus_if.forceEndTransaction); end
    tick();
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL bto_pulse_width: got %b want 0", bus_if.timeoutPulse); end
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0100) begin n_fail++; $display("FAIL bto_next: got %b want 0100", bus_if.busGrant); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_begin_at_expiry();
    do_reset();
    bus_if.requestBus = 4'b0001;
    tick();
    repeat (15) tick();
    bus_if.beginTransaction = 4'b0001;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0001) begin n_fail++; $display("FAIL bexp_grant: got %b want 0001", bus_if.busGrant); end
    n_cmp++; if (bus_if.busActive !== 1'b1) begin n_fail++; $display("FAIL bexp_active: got %b want 1", bus_if.busActive); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL bexp_pulse: got %b want 0", bus_if.timeoutPulse); end
    bus_if.beginTransaction = 4'b0000;
    bus_if.endTransaction   = 4'b0001;
    bus_if.requestBus       = 4'b0000;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_error_and_end();
    do_reset();
    bus_if.requestBus = 4'b0001;
    tick();
    bus_if.beginTransaction = 4'b0001;
    tick();
    bus_if.beginTransaction = 4'b0000;
    tick();
    bus_if.endTransaction = 4'b0001;
    bus_if.busErrorIn     = 1'b1;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL err_grant: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", bus_if.timeoutPulse); end
    n_cmp++; if (bus_if.busActive !== 1'b1) begin n_fail++; $display("FAIL err_active_tail: got %b want 1", bus_if.busActive); end
    bus_if.endTransaction = 4'b0000;
    bus_if.busErrorIn     = 1'b0;
    tick();
    n_cmp++; if (bus_if.busActive !== 1'b0) begin n_fail++; $display("FAIL err_active_low: got %b want 0", bus_if.busActive); end
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL err_idle_grant: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL err_idle_pulse: got %b want 0", bus_if.timeoutPulse); end
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0001) begin n_fail++; $display("FAIL err_regrant: got %b want 0001", bus_if.busGrant); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_active_timeout();
    int k;
    bit dropped;
    k = 0;
    dropped = 1'b0;
    do_reset();
    bus_if.requestBus = 4'b0101;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0001) begin n_fail++; $display("FAIL ato_grant: got %b want 0001", bus_if.busGrant); end
    bus_if.beginTransaction = 4'b0101;
    tick();
    n_cmp++; if (bus_if.busActive !== 1'b1) begin n_fail++; $display("FAIL ato_active: got %b want 1", bus_if.busActive); end
    // Non-owner master 2 keeps its begin/end high; the arbiter must ignore it.
    bus_if.beginTransaction = 4'b0100;
    bus_if.endTransaction   = 4'b0100;
    for (int i = 0; i < 60; i++) begin
      tick();
      k++;
      if (bus_if.timeoutPulse) break;
      if (bus_if.busGrant !== 4'b0001) dropped = 1'b1;
    end
    n_cmp++; if (k !== 32) begin n_fail++; $display("FAIL ato_cycles: got %0d want 32", k); end
    n_cmp++; if (bus_if.forceEndTransaction !== 1'b1) begin n_fail++; $display("FAIL ato_force: got %b want 1", bus_if.forceEndTransaction); end
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL ato_grant_drop: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (dropped !== 1'b0) begin n_fail++; $display("FAIL ato_nonowner_end: got early drop %b want 0", dropped); end
    clear_inputs();
    tick();
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL ato_pulse_width: got %b want 0", bus_if.timeoutPulse); end
    n_cmp++; if (bus_if.forceEndTransaction !== 1'b0) begin n_fail++; $display("FAIL ato_force_width: got %b want 0", bus_if.forceEndTransaction); end
    tick();
  endtask

  task automatic test_end_at_expiry();
    do_reset();
    bus_if.requestBus = 4'b0001;
    tick();
    bus_if.beginTransaction = 4'b0001;
    tick();
    bus_if.beginTransaction = 4'b0000;
    repeat (31) tick();
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL eexp_early: got %b want 0", bus_if.timeoutPulse); end
    bus_if.endTransaction = 4'b0001;
    tick();
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL eexp_pulse: got %b want 0", bus_if.timeoutPulse); end
    n_cmp++; if (bus_if.forceEndTransaction !== 1'b0) begin n_fail++; $display("FAIL eexp_force: got %b want 0", bus_if.forceEndTransaction); end
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL eexp_grant: got %b want 0000", bus_if.busGrant); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_in_active();
    do_reset();
    bus_if.requestBus = 4'b0110;
    tick();
    bus_if.beginTransaction = 4'b0010;
    tick();
    bus_if.beginTransaction = 4'b0000;
    bus_if.endTransaction   = 4'b0010;
    bus_if.requestBus       = 4'b0100;
    tick();
    bus_if.endTransaction = 4'b0000;
    tick();
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0100) begin n_fail++; $display("FAIL rst_act_grant2: got %b want 0100", bus_if.busGrant); end
    bus_if.beginTransaction = 4'b0100;
    tick();
    n_cmp++; if (bus_if.busActive !== 1'b1) begin n_fail++; $display("FAIL rst_act_active: got %b want 1", bus_if.busActive); end
    reset = 1'b1;
    clear_inputs();
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0000) begin n_fail++; $display("FAIL rst_act_grant: got %b want 0000", bus_if.busGrant); end
    n_cmp++; if (bus_if.busOwner !== 2'd0) begin n_fail++; $display("FAIL rst_act_owner: got %0d want 0", bus_if.busOwner); end
    n_cmp++; if (bus_if.busActive !== 1'b0) begin n_fail++; $display("FAIL rst_act_busactive: got %b want 0", bus_if.busActive); end
    n_cmp++; if (bus_if.timeoutPulse !== 1'b0) begin n_fail++; $display("FAIL rst_act_pulse: got %b want 0", bus_if.timeoutPulse); end
    n_cmp++; if (bus_if.forceEndTransaction !== 1'b0) begin n_fail++; $display("FAIL rst_act_force: got %b want 0", bus_if.forceEndTransaction); end
    reset = 1'b0;
    bus_if.requestBus = 4'b0101;
    tick();
    n_cmp++; if (bus_if.busGrant !== 4'b0001) begin n_fail++; $display("FAIL rst_act_next: got %b want 0001", bus_if.busGrant); end
    clear_inputs();
    tick();
    tick();
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_two_requesters();
    test_round_robin();
    test_begin_timeout();
    test_begin_at_expiry();
    test_error_and_end();
    test_active_timeout();
    test_end_at_expiry();
    test_reset_in_active();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter beginTimeout, default 8'd16: cycles a granted master may take to assert beginTransaction before its grant is revoked.
REQ-002 SHALL have parameter activeTimeout, default 16'd4096: maximum cycles one transaction (begin to end) may hold the bus.
REQ-003 SHALL have port clock, input, 1: single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port requestBus, input, 4: bus request per master; bit i = master i (0 = CPU, 1 = camera, 2/3 = other DMA masters).
REQ-006 SHALL have port beginTransaction, input, 4: per-master beginTransactionOut, OR'ed onto the shared bus.
REQ-007 SHALL have port endTransaction, input, 4: per-master endTransactionOut.
REQ-008 SHALL have port busErrorIn, input, 1: bus error from the slave side.
REQ-009 SHALL have port busGrant, output, 4: one-hot or zero grant vector, registered.
REQ-010 SHALL have port busOwner, output, 2: index of the granted master; 0 when none is granted.
REQ-011 SHALL have port busActive, output, 1: high from the cycle after the accepted begin through the cycle after end.
REQ-012 SHALL have port timeoutPulse, output, 1: one-cycle pulse on any revoke caused by a timeout.
REQ-013 SHALL have port forceEndTransaction, output, 1: one-cycle pulse requesting that the bus slaves abort, driven on an active timeout.

Function
REQ-014 SHALL implement the states IDLE, GRANTED, ACTIVE and RELEASE.
REQ-015 IDLE: if any requestBus bit is set, select the winner by round-robin and go to GRANTED; busGrant SHALL be asserted on the next clock edge, giving 1 cycle of latency from request to grant.
REQ-016 Round-robin: search starts at (lastOwner+1) mod 4 and increments with wrap 3->0; after reset, lastOwner = 3, so master 0 has highest priority.
REQ-017 GRANTED: if beginTransaction[owner] is set, go to ACTIVE.
REQ-018 GRANTED: else if requestBus[owner] has dropped, go to RELEASE with no timeout.
REQ-019 GRANTED: else if the begin counter reaches beginTimeout-1, go to RELEASE and pulse timeoutPulse.
REQ-020 ACTIVE: on endTransaction[owner] or busErrorIn, go to RELEASE.
REQ-021 ACTIVE: on activeTimeout expiry, go to RELEASE and pulse both timeoutPulse and forceEndTransaction.
REQ-022 RELEASE: busGrant SHALL be 0 for exactly one cycle, lastOwner <= owner, then go to IDLE; this cycle is the mandatory bus turnaround.
REQ-023 Signals from a non-owner SHALL be ignored: beginTransaction/endTransaction bits other than owner have no effect.
REQ-024 If endTransaction[owner] and busErrorIn assert in the same cycle, the arbiter SHALL make one RELEASE transition and SHALL NOT pulse timeoutPulse.
REQ-025 If beginTransaction[owner] asserts in the same cycle the begin counter expires, begin wins and the state goes to ACTIVE.
REQ-026 If endTransaction[owner] asserts in the same cycle as activeTimeout expiry, end wins and there is no pulse.
REQ-027 The begin counter (8 bit) SHALL clear on entry to GRANTED and count up while in GRANTED.
REQ-028 The active counter (16 bit) SHALL clear on entry to ACTIVE and saturate, never wrapping.
REQ-029 The arbiter SHALL grant a master holding requestBus continuously again only after it wins round-robin, so no master can monopolise the bus.
REQ-030 With a single requester, back-to-back transactions SHALL be separated by the RELEASE cycle plus the IDLE cycle, i.e. 2 idle cycles.
REQ-031 All outputs SHALL be registered; no combinational path from input to output.

Reset
REQ-032 On reset the arbiter SHALL hold these values in the same cycle: state IDLE, busGrant 4'b0000, busOwner 0, busActive 0, timeoutPulse 0, forceEndTransaction 0, lastOwner 3, both counters 0.
REQ-033 Reset during GRANTED or ACTIVE SHALL drop the grant on the next edge with no timeoutPulse; the master side is reset by the same signal.

Structure
REQ-034 A shared package SHALL hold the state encoding (IDLE=2'd0, GRANTED=2'd1, ACTIVE=2'd2, RELEASE=2'd3) and the constant NR_OF_MASTERS=4.
REQ-035 The round-robin selection SHALL be one combinational sub-module, roundRobinSelect, with inputs request[3:0] and lastOwner[1:0] and outputs winner[1:0] and valid.

Verification
REQ-036 Reset, then requestBus=4'b0110 in IDLE -> busGrant=4'b0010 one cycle later; after end, RELEASE, IDLE -> busGrant=4'b0100.
REQ-037 All 4 masters request continuously, each ending its transaction 3 cycles after grant -> grant order 0,1,2,3,0 with exactly 2 grant-low cycles between consecutive grants.
REQ-038 Master 1 granted and never asserts begin -> after 16 cycles busGrant=0, timeoutPulse=1 for 1 cycle, next grant goes to master 2 if it is requesting.
REQ-039 Master 0 active; busErrorIn and endTransaction[0] high in the same cycle -> single RELEASE, timeoutPulse=0, busActive low next cycle.
REQ-040 Run with activeTimeout=32 and the owner never ends -> forceEndTransaction and timeoutPulse pulse once at cycle 32 after begin; endTransaction[2] from non-owner master 2 while master 0 is active -> ignored.
REQ-041 Assert reset in ACTIVE -> all outputs reach their reset values on the next edge, and the next grant goes to master 0.
